ntt_radix_2_ctrl: RTL

In-place iterative NTT/INTT sequencer that drives the radix-2 butterfly core and its coefficient and twiddle memories. On `start` it walks every stage, group and butterfly of an N-point transform. Each cycle it issues one coefficient read pair and one twiddle address. It delays the addresses through a pipeline matched to memory-read plus butterfly latency and issues the matching write-back pair. It is address/control only: data flows memory → butterfly → memory outside this block.

---
 rtl/ntt_radix_2_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/ntt_radix_2_ctrl.sv
// ntt_radix_2_ctrl: in-place radix-2 NTT/INTT address sequencer with write-back delay line
module ntt_radix_2_ctrl #(
  parameter int N      = 256,
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             bf_select,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_1,
  output logic [LOG2N-1:0] rd_addr_2,
  output logic [LOG2N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_1,
  output logic [LOG2N-1:0] wr_addr_2
);
  localparam int D  = 1 + BF_LAT;
  localparam int DW = $clog2(D + 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(LOG2N - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t           state_q;
  logic [LOG2N-1:0] s_q, g_q, j_q;
  logic [DW-1:0]    d_q;
  logic [2*LOG2N:0] sr_q [D];
  logic [LOG2N-1:0] lsh, len_m1, grp_m1, a1, a2, tw;
  logic             last_j, last_g, last_s;
  // lsh = log2(len): NTT halves the butterfly span each stage, INTT doubles it
  always_comb begin
    lsh    = bf_select ? s_q : LAST - s_q;
    len_m1 = (ONE << lsh) - ONE;
    grp_m1 = (ONE << (LAST - lsh)) - ONE;
    a1     = (g_q << (lsh + ONE)) | j_q;
    a2     = a1 + (ONE << lsh);
    tw     = bf_select ? ({LOG2N{1'b1}} >> s_q) - g_q : (ONE << s_q) + g_q;
    last_j = j_q == len_m1;
    last_g = g_q == grp_m1;
    last_s = s_q == LAST;
  end
  assign {wr_en, wr_addr_1, wr_addr_2} = sr_q[D-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      g_q       <= '0;
      j_q       <= '0;
      d_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bf_select <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_1 <= '0;
      rd_addr_2 <= '0;
      tw_addr   <= '0;
      for (int i = 0; i < D; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= {rd_en, rd_addr_1, rd_addr_2};
      for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bf_select <= mode;
            s_q       <= '0;
            g_q       <= '0;
            j_q       <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          busy      <= 1'b1;
          rd_en     <= 1'b1;
          rd_addr_1 <= a1;
          rd_addr_2 <= a2;
          tw_addr   <= tw;
          j_q       <= last_j ? '0 : j_q + ONE;
          if (last_j) g_q <= last_g ? '0 : g_q + ONE;
          if (last_j && last_g) begin
            d_q     <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          rd_en <= 1'b0;
          d_q   <= d_q + DW'(1);
          if (d_q == DW'(D - 1)) begin
            if (!last_s) s_q <= s_q + ONE;
            state_q <= last_s ? FIN : ISSUE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
